// File: rtl/puf_sequencer.sv
// Sequences one PUF operation (raw, corrected, hashed or enroll) across the PUF,
// error-correction and SHA engines, with a per-wait-state timeout watchdog.
module puf_sequencer #(
  parameter int CHAL_W      = 8,
  parameter int RESP_W      = 256,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [CHAL_W-1:0] challenge_in,
  output logic              busy,
  output logic              puf_start,
  output logic [CHAL_W-1:0] puf_challenge,
  input  logic              puf_done,
  input  logic [RESP_W-1:0] puf_response,
  output logic              ec_start,
  input  logic              ec_ready,
  input  logic [RESP_W-1:0] ec_corrected,
  output logic              sha_init,
  input  logic              sha_digest_valid,
  input  logic [RESP_W-1:0] sha_digest,
  output logic              mem_we,
  output logic [CHAL_W-1:0] mem_addr,
  output logic [RESP_W-1:0] resp_out,
  output logic              resp_valid,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] M_RAW = 2'b00;
  localparam logic [1:0] M_EC  = 2'b01;
  localparam logic [1:0] M_ENR = 2'b11;

  typedef enum logic [2:0] {
    IDLE, PUF_WAIT, EC_WAIT, SHA_WAIT, ENROLL, DONE
  } state_t;

  state_t            state, state_n;
  logic [1:0]        mode_q, mode_n;
  logic [CHAL_W-1:0] chal_q, chal_n;
  logic [RESP_W-1:0] res_q, res_n, resp_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              busy_n, puf_start_n, ec_start_n, sha_init_n, mem_we_n;
  logic              resp_valid_n, tout_n, timed_out;

  assign timed_out     = (cnt == CNT_LAST);
  assign puf_challenge = chal_q;
  assign mem_addr      = chal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mode_q      <= '0;
      chal_q      <= '0;
      res_q       <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      puf_start   <= 1'b0;
      ec_start    <= 1'b0;
      sha_init    <= 1'b0;
      mem_we      <= 1'b0;
      resp_out    <= '0;
      resp_valid  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      mode_q      <= mode_n;
      chal_q      <= chal_n;
      res_q       <= res_n;
      cnt         <= cnt_n;
      busy        <= busy_n;
      puf_start   <= puf_start_n;
      ec_start    <= ec_start_n;
      sha_init    <= sha_init_n;
      mem_we      <= mem_we_n;
      resp_out    <= resp_n;
      resp_valid  <= resp_valid_n;
      timeout_err <= tout_n;
    end
  end

  // All outputs are computed one cycle early here and registered, so a strobe
  // is visible during the first cycle of the state it launches.
  always_comb begin
    state_n      = state;
    mode_n       = mode_q;
    chal_n       = chal_q;
    res_n        = res_q;
    resp_n       = resp_out;
    cnt_n        = '0;
    puf_start_n  = 1'b0;
    ec_start_n   = 1'b0;
    sha_init_n   = 1'b0;
    mem_we_n     = 1'b0;
    resp_valid_n = 1'b0;
    tout_n       = timeout_err;
    case (state)
      IDLE: begin
        if (start) begin
          mode_n      = mode;
          chal_n      = challenge_in;
          tout_n      = 1'b0;
          puf_start_n = 1'b1;
          state_n     = PUF_WAIT;
        end
      end
      PUF_WAIT: begin
        if (puf_done) begin
          res_n = puf_response;
          if (mode_q == M_RAW) begin
            resp_n       = puf_response;
            resp_valid_n = 1'b1;
            state_n      = DONE;
          end else if (mode_q == M_ENR) begin
            mem_we_n = 1'b1;
            state_n  = ENROLL;
          end else begin
            ec_start_n = 1'b1;
            state_n    = EC_WAIT;
          end
        end else if (timed_out) begin
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      EC_WAIT: begin
        if (ec_ready) begin
          res_n = ec_corrected;
          if (mode_q == M_EC) begin
            resp_n       = ec_corrected;
            resp_valid_n = 1'b1;
            state_n      = DONE;
          end else begin
            sha_init_n = 1'b1;
            state_n    = SHA_WAIT;
          end
        end else if (timed_out) begin
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SHA_WAIT: begin
        if (sha_digest_valid) begin
          res_n        = sha_digest;
          resp_n       = sha_digest;
          resp_valid_n = 1'b1;
          state_n      = DONE;
        end else if (timed_out) begin
          tout_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ENROLL: begin
        resp_n       = res_q;
        resp_valid_n = 1'b1;
        state_n      = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_puf_sequencer.sv
// Directed bench: one instance with the default timeout, one with TIMEOUT_CYC=16.
module tb_puf_sequencer;
  logic         clk = 1'b0;
  logic         reset, start_a, start_b;
  logic [1:0]   mode;
  logic [7:0]   challenge;
  logic         puf_done, ec_ready, sha_digest_valid;
  logic [255:0] puf_response, ec_corrected, sha_digest;

  logic         busy_a, puf_start_a, ec_start_a, sha_init_a, mem_we_a, resp_valid_a, timeout_err_a;
  logic [7:0]   puf_challenge_a, mem_addr_a;
  logic [255:0] resp_out_a;
  logic         busy_b, puf_start_b, ec_start_b, sha_init_b, mem_we_b, resp_valid_b, timeout_err_b;
  logic [7:0]   puf_challenge_b, mem_addr_b;
  logic [255:0] resp_out_b;

  int n_chk = 0, n_fail = 0;
  int n_ps = 0, n_ec = 0, n_sha = 0, n_we = 0, n_rv = 0, n_rv_b = 0;

  localparam logic [255:0] RAW = {32{8'hA5}};
  localparam logic [255:0] R2  = {16{16'h1234}};
  localparam logic [255:0] C1  = {8{32'h01234567}};
  localparam logic [255:0] D1  = {8{32'hDEADBEEF}};
  localparam logic [255:0] R3  = {8{32'hCAFEF00D}};

  always #5 clk = ~clk;

  puf_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .mode(mode), .challenge_in(challenge),
    .busy(busy_a), .puf_start(puf_start_a), .puf_challenge(puf_challenge_a),
    .puf_done(puf_done), .puf_response(puf_response),
    .ec_start(ec_start_a), .ec_ready(ec_ready), .ec_corrected(ec_corrected),
    .sha_init(sha_init_a), .sha_digest_valid(sha_digest_valid), .sha_digest(sha_digest),
    .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .resp_out(resp_out_a), .resp_valid(resp_valid_a), .timeout_err(timeout_err_a)
  );

  puf_sequencer #(.TIMEOUT_CYC(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .mode(mode), .challenge_in(challenge),
    .busy(busy_b), .puf_start(puf_start_b), .puf_challenge(puf_challenge_b),
    .puf_done(puf_done), .puf_response(puf_response),
    .ec_start(ec_start_b), .ec_ready(ec_ready), .ec_corrected(ec_corrected),
    .sha_init(sha_init_b), .sha_digest_valid(sha_digest_valid), .sha_digest(sha_digest),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .resp_out(resp_out_b), .resp_valid(resp_valid_b), .timeout_err(timeout_err_b)
  );

  // strobe counters sampled mid-cycle
  always @(negedge clk) begin
    if (puf_start_a)  n_ps++;
    if (ec_start_a)   n_ec++;
    if (sha_init_a)   n_sha++;
    if (mem_we_a)     n_we++;
    if (resp_valid_a) n_rv++;
    if (resp_valid_b) n_rv_b++;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int s_ps, s_ec, s_sha, s_we, s_rv;
    logic ok;
    reset = 1'b1; start_a = 0; start_b = 0; mode = 0; challenge = 0;
    puf_done = 0; ec_ready = 0; sha_digest_valid = 0;
    puf_response = '0; ec_corrected = '0; sha_digest = '0;
    #3;
    chk("rst_busy", busy_a, 0);
    chk("rst_strobes", {puf_start_a, ec_start_a, sha_init_a, mem_we_a, resp_valid_a}, 0);
    chk("rst_resp", resp_out_a, 0);
    chk("rst_tout", timeout_err_a, 0);
    chk("rst_chal", puf_challenge_a, 0);
    tick(); reset = 1'b0; tick();

    // raw mode
    s_ec = n_ec;
    mode = 2'b00; challenge = 8'h5A; start_a = 1; tick(); start_a = 0;
    chk("raw_puf_start", puf_start_a, 1);
    chk("raw_busy", busy_a, 1);
    chk("raw_chal", puf_challenge_a, 8'h5A);
    tick();
    chk("raw_puf_start_1cyc", puf_start_a, 0);
    repeat (9) tick();
    puf_done = 1; puf_response = RAW; tick(); puf_done = 0; puf_response = '0;
    chk("raw_valid", resp_valid_a, 1);
    chk("raw_resp", resp_out_a, RAW);
    tick();
    chk("raw_valid_1cyc", resp_valid_a, 0);
    chk("raw_idle", busy_a, 0);
    chk("raw_hold", resp_out_a, RAW);
    chk("raw_no_ec", n_ec - s_ec, 0);

    // hashed mode
    s_ec = n_ec; s_sha = n_sha; ok = 1;
    mode = 2'b10; challenge = 8'h11; start_a = 1; tick(); start_a = 0;
    repeat (3) begin ok &= busy_a; tick(); end
    puf_done = 1; puf_response = R2; tick(); puf_done = 0;
    chk("hash_ec_start", ec_start_a, 1);
    repeat (5) begin ok &= busy_a; tick(); end
    ec_ready = 1; ec_corrected = C1; tick(); ec_ready = 0;
    chk("hash_sha_init", sha_init_a, 1);
    chk("hash_no_early_valid", resp_valid_a, 0);
    repeat (64) begin ok &= busy_a; tick(); end
    sha_digest_valid = 1; sha_digest = D1; tick(); sha_digest_valid = 0;
    ok &= busy_a;
    chk("hash_valid", resp_valid_a, 1);
    chk("hash_resp", resp_out_a, D1);
    chk("hash_busy_all", ok, 1);
    tick();
    chk("hash_idle", busy_a, 0);
    chk("hash_ec_once", n_ec - s_ec, 1);
    chk("hash_sha_once", n_sha - s_sha, 1);

    // enroll
    s_we = n_we;
    mode = 2'b11; challenge = 8'h03; start_a = 1; tick(); start_a = 0;
    tick();
    puf_done = 1; puf_response = R3; tick(); puf_done = 0;
    chk("enr_we", mem_we_a, 1);
    chk("enr_addr", mem_addr_a, 8'h03);
    chk("enr_no_valid_yet", resp_valid_a, 0);
    tick();
    chk("enr_we_1cyc", mem_we_a, 0);
    chk("enr_valid", resp_valid_a, 1);
    chk("enr_resp", resp_out_a, R3);
    tick();
    chk("enr_we_once", n_we - s_we, 1);

    // timeout in EC_WAIT, TIMEOUT_CYC=16
    s_rv = n_rv_b;
    mode = 2'b01; challenge = 8'h42; start_b = 1; tick(); start_b = 0;
    puf_done = 1; puf_response = RAW; tick(); puf_done = 0;
    chk("to_ec_start", ec_start_b, 1);
    repeat (15) tick();
    chk("to_busy_15", busy_b, 1);
    tick();
    chk("to_idle_16", busy_b, 0);
    chk("to_err", timeout_err_b, 1);
    chk("to_no_valid", n_rv_b - s_rv, 0);
    chk("to_resp_kept", resp_out_b, 0);
    // restart clears the error; puf_done exactly on the timeout boundary wins
    mode = 2'b00; start_b = 1; tick(); start_b = 0;
    chk("to_err_cleared", timeout_err_b, 0);
    repeat (15) tick();
    chk("edge_busy", busy_b, 1);
    puf_done = 1; puf_response = R2; tick(); puf_done = 0;
    chk("edge_valid", resp_valid_b, 1);
    chk("edge_resp", resp_out_b, R2);
    chk("edge_no_err", timeout_err_b, 0);
    tick();
    chk("edge_err_after", timeout_err_b, 0);

    // extra start ignored, then reset in SHA_WAIT
    s_ps = n_ps;
    mode = 2'b10; challenge = 8'h3C; start_a = 1; tick(); start_a = 0;
    tick();
    mode = 2'b00; challenge = 8'h77; start_a = 1; tick(); start_a = 0;
    chk("ign_chal", puf_challenge_a, 8'h3C);
    chk("ign_busy", busy_a, 1);
    puf_done = 1; puf_response = R3; tick(); puf_done = 0;
    chk("ign_mode_kept", ec_start_a, 1);
    ec_ready = 1; tick(); ec_ready = 0;
    chk("ign_sha_init", sha_init_a, 1);
    chk("ign_one_puf_start", n_ps - s_ps, 1);
    s_rv = n_rv; s_we = n_we;
    #2 reset = 1'b1; #1;
    chk("mrst_busy", busy_a, 0);
    chk("mrst_strobes", {puf_start_a, ec_start_a, sha_init_a, mem_we_a, resp_valid_a}, 0);
    chk("mrst_resp", resp_out_a, 0);
    chk("mrst_chal", puf_challenge_a, 0);
    chk("mrst_tout_b", timeout_err_b, 0);
    tick(); #2 reset = 1'b0;
    sha_digest_valid = 1; sha_digest = D1; tick(); sha_digest_valid = 0;
    tick();
    chk("mrst_no_valid", n_rv - s_rv, 0);
    chk("mrst_no_we", n_we - s_we, 0);
    chk("mrst_idle", busy_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
